// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore sequencer for a multi-cycle MIPS-subset datapath.
// Sequences one instruction over 3-5 cycles, stalls on the memory handshake,
// flags unsupported opcodes and counts retired instructions.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | 0  read instruction at PC, PC <= PC + 4 when memory completes
// DECODE   | 1  latch opcode, precompute branch target into ALUOut
// MEMADR   | 2  effective address rs + sign-extended immediate
// MEMRD    | 3  load data read at ALUOut, waits on mem_ready
// MEMWB    | 4  write MDR into rt
// MEMWR    | 5  store rt at ALUOut, waits on mem_ready
// EXEC     | 6  R-type ALU operation, function from funct field
// RWB      | 7  write ALUOut into rd
// BRANCH   | 8  compare rs/rt, conditional PC load from ALUOut
// JUMP     | 9  unconditional PC load of jump target
// IEXEC    | 10 immediate ALU operation (addi/andi/ori)
// IWB      | 11 write ALUOut into rt
// ILLEGAL  | 12 one-cycle illegal pulse, instruction not retired
// 13..15   | unused, fall back to FETCH with all outputs idle
module multi_cycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic [1:0]       Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_rdy;
  logic             retire;
  logic             beq_q, bne_q;

  // With the handshake disabled, memory is treated as always ready.
  assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;
  assign beq_q   = (op_q == OP_BEQ);
  assign bne_q   = (op_q == OP_BNE);

  // State, opcode latch and retire counter; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, opcode capture and retire decision.
  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        // The live opcode is only trusted here; later states use op_q.
        op_d = OP;
        case (OP)
          OP_LW, OP_SW:                state_d = S_MEMADR;
          OP_R:                        state_d = S_EXEC;
          OP_BEQ, OP_BNE:              state_d = S_BRANCH;
          OP_J:                        state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:    state_d = S_IEXEC;
          default:                     state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        state_d = mem_rdy ? S_FETCH : S_MEMWR;
        retire  = mem_rdy;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB, S_BRANCH, S_JUMP, S_IWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_IEXEC:  state_d = S_IWB;
      S_ILLEGAL: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  // Moore outputs; everything idles while reset is held so an aborted
  // instruction can never fire a write strobe in the reset cycle.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 2'b00;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUop    = 3'b000;
    PCSource = 2'b00;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_rdy;
          PCWrite = mem_rdy;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUop   = 3'b010;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUop    = 3'b001;
          PCSource = 2'b01;
          Branch   = {bne_q, beq_q};
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (op_q)
            OP_ANDI: ALUop = 3'b100;
            OP_ORI:  ALUop = 3'b101;
            default: ALUop = 3'b000;
          endcase
        end
        S_IWB:     RegWrite = 1'b1;
        S_ILLEGAL: illegal  = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = rst ? 4'd0 : state_q;
  assign retired = rst ? '0 : retired_q;

endmodule
